// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-size encodings and responder state enumeration
package dmem_responder_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane store merge and load extraction/extension
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);
    logic [4:0]  w_sh;
    logic [31:0] w_mask;
    logic [31:0] w_rshift;
    // merge store data into the addressed lanes; shift the load lane down and extend it
    always_comb begin
        w_sh     = {i_lane, 3'b000};
        w_mask   = (i_size == SZ_BYTE) ? (32'h0000_00FF << w_sh) :
                   (i_size == SZ_HALF) ? (32'h0000_FFFF << w_sh) : 32'hFFFF_FFFF;
        o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
        w_rshift = i_word >> w_sh;
        o_rdata  = (i_size == SZ_BYTE) ? {{24{~i_unsigned & w_rshift[7]}}, w_rshift[7:0]} :
                   (i_size == SZ_HALF) ? {{16{~i_unsigned & w_rshift[15]}}, w_rshift[15:0]} : i_word;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory answering load/store requests after a fixed wait
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int AW = $clog2(DEPTH);
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH];
    logic        w_idle;
    logic        w_commit;
    logic        w_we;
    logic        w_uns;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_size;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [31:0] w_merged;
    logic [31:0] w_rdata;
    // with no wait the access happens on the accepting edge, so use the live request then
    always_comb begin
        w_idle   = r_state == ST_IDLE;
        w_commit = i_rst_n && ((w_idle && i_req_valid && WAIT == 0) || (r_state == ST_WAIT && r_cnt == 4'd0));
        w_we     = w_idle ? i_req_we : r_we;
        w_uns    = w_idle ? i_req_unsigned : r_uns;
        w_addr   = w_idle ? i_req_addr : r_addr;
        w_wdata  = w_idle ? i_req_wdata : r_wdata;
        w_size   = w_idle ? i_req_size : r_size;
        w_err    = w_size == 2'b11 || (w_size == SZ_HALF && w_addr[0]) ||
                   (w_size == SZ_WORD && w_addr[1:0] != 2'b00) || w_addr >= 32'(4 * DEPTH);
        w_idx    = w_addr[AW+1:2];
        w_word   = r_mem[w_idx];
    end
    dmem_lane_align u_align (
        .i_size     (w_size),
        .i_lane     (w_addr[1:0]),
        .i_unsigned (w_uns),
        .i_word     (w_word),
        .i_wdata    (w_wdata),
        .o_merged   (w_merged),
        .o_rdata    (w_rdata)
    );
    // storage commits only valid stores, on the edge entering RESP; never reset
    always_ff @(posedge i_clk) begin
        if (w_commit && w_we && !w_err) r_mem[w_idx] <= w_merged;
    end
    // request/response state machine with registered handshake and response outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= SZ_BYTE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_req_valid) begin
                    r_we        <= i_req_we;
                    r_uns       <= i_req_unsigned;
                    r_addr      <= i_req_addr;
                    r_wdata     <= i_req_wdata;
                    r_size      <= i_req_size;
                    r_req_ready <= 1'b0;
                    r_state     <= (WAIT == 0) ? ST_RESP : ST_WAIT;
                    r_cnt       <= (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
                end
                ST_WAIT: begin
                    r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
                    if (r_cnt == 4'd0) r_state <= ST_RESP;
                end
                ST_RESP: if (i_rsp_ready) begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_we || w_err) ? 32'd0 : w_rdata;
            end
        end
    end
    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors against a byte-array memory model, three WAIT settings
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n [3];
    logic        req_valid [3];
    logic        req_we [3];
    logic        req_uns [3];
    logic        rsp_ready [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [1:0]  req_size [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_err [3];
    logic [31:0] rsp_rdata [3];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit          pend [3];
    int          rsp_cyc [3];
    logic [31:0] exp_rdata [3];
    logic        exp_err [3];
    logic [7:0]  mm [3][256];

    dmem_responder #(.DEPTH(64), .WAIT(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_size(req_size[0]),
        .i_req_unsigned(req_uns[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));
    dmem_responder #(.DEPTH(64), .WAIT(3)) u_w3 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_size(req_size[1]),
        .i_req_unsigned(req_uns[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));
    dmem_responder #(.DEPTH(64), .WAIT(0)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_we(req_we[2]), .i_req_addr(req_addr[2]), .i_req_wdata(req_wdata[2]), .i_req_size(req_size[2]),
        .i_req_unsigned(req_uns[2]), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
        .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wof(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h at cycle %0d", name, k, act, exp, cyc);
        end
    endtask

    // expected response from the memory contents: little-endian bytes, then extension
    function automatic void model(input int k, input bit we, input logic [31:0] addr, input logic [1:0] size,
                                  input bit uns, output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        err = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) || addr >= 256;
        rd = 32'd0;
        if (!err && !we) begin
            n = 1 << size;
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[k][int'(addr[7:0]) + i];
            if (n == 1) rd = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (n == 2) rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else rd = v;
        end
    endfunction

    task automatic do_req(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns, input int hold,
                          input logic [31:0] lit, input logic lit_err);
        int acc;
        int t;
        logic e;
        logic [31:0] r;
        t = 0;
        while (!req_ready[k] && t < 50) begin @(posedge clk); #1; t++; end
        check("req_ready_before", k, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
        req_size[k] = size; req_uns[k] = uns;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        acc = cyc;
        model(k, we, addr, size, uns, e, r);
        exp_err[k] = e; exp_rdata[k] = r; rsp_cyc[k] = acc + wof(k); pend[k] = 1'b1;
        t = 0;
        while (!rsp_valid[k] && t < 50) begin @(posedge clk); #1; t++; end
        check("latency", k, cyc, rsp_cyc[k]);
        check("model_rdata", k, r, lit);
        check("model_err", k, 32'(e), 32'(lit_err));
        check("lit_rdata", k, rsp_rdata[k], lit);
        check("lit_err", k, 32'(rsp_err[k]), 32'(lit_err));
        if (we && !e) for (int i = 0; i < (1 << size); i++) mm[k][int'(addr[7:0]) + i] = wdata[8*i +: 8];
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        pend[k] = 1'b0;
    endtask

    // every cycle: handshake outputs and, while a response is due, its payload
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit ev;
            ev = pend[k] && cyc >= rsp_cyc[k];
            check("rsp_valid", k, 32'(rsp_valid[k]), 32'(ev));
            check("req_ready", k, 32'(req_ready[k]), 32'(!pend[k]));
            if (ev) begin
                check("rsp_rdata", k, rsp_rdata[k], exp_rdata[k]);
                check("rsp_err", k, 32'(rsp_err[k]), 32'(exp_err[k]));
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_uns[k] = 1'b0; rsp_ready[k] = 1'b0;
            req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_size[k] = 2'b00;
            pend[k] = 1'b0; rsp_cyc[k] = 0; exp_rdata[k] = 32'd0; exp_err[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", k, 32'(req_ready[k]), 32'd1);
            check("reset_valid", k, 32'(rsp_valid[k]), 32'd0);
            check("reset_rdata", k, rsp_rdata[k], 32'd0);
            check("reset_err", k, 32'(rsp_err[k]), 32'd0);
            rst_n[k] = 1'b1;
        end
        @(posedge clk); #1;
        // WAIT=1 instance
        do_req(0, 1, 32'h00, 32'h1234_5678, 2'b10, 0, 0, 32'h0, 0);
        do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0, 0);
        do_req(0, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'hDEAD_BEEF, 0);
        do_req(0, 1, 32'h11, 32'h0000_0080, 2'b00, 0, 0, 32'h0, 0);
        do_req(0, 0, 32'h11, 32'h0,         2'b00, 0, 0, 32'hFFFF_FF80, 0);
        do_req(0, 0, 32'h11, 32'h0,         2'b00, 1, 0, 32'h0000_0080, 0);
        do_req(0, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'hDEAD_80EF, 0);
        do_req(0, 0, 32'h13, 32'h0,         2'b01, 0, 0, 32'h0, 1);
        do_req(0, 0, 32'h12, 32'h0,         2'b10, 0, 0, 32'h0, 1);
        do_req(0, 0, 32'h10, 32'h0,         2'b11, 0, 0, 32'h0, 1);
        do_req(0, 1, 32'h10, 32'h0,         2'b11, 0, 0, 32'h0, 1);
        do_req(0, 1, 32'h11, 32'hFFFF_FFFF, 2'b01, 0, 0, 32'h0, 1);
        do_req(0, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'hDEAD_80EF, 0);
        do_req(0, 1, 32'h100, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h0, 1);
        do_req(0, 0, 32'h00, 32'h0,         2'b10, 0, 0, 32'h1234_5678, 0);
        do_req(0, 0, 32'h12, 32'h0,         2'b01, 1, 0, 32'h0000_DEAD, 0);
        do_req(0, 0, 32'h12, 32'h0,         2'b01, 0, 0, 32'hFFFF_DEAD, 0);
        do_req(0, 0, 32'h10, 32'h0,         2'b01, 0, 0, 32'hFFFF_80EF, 0);
        do_req(0, 0, 32'h10, 32'h0,         2'b10, 1, 5, 32'hDEAD_80EF, 0);
        do_req(0, 1, 32'h14, 32'h0,         2'b10, 0, 0, 32'h0, 0);
        do_req(0, 1, 32'h16, 32'h1234_A5A5, 2'b01, 0, 0, 32'h0, 0);
        do_req(0, 0, 32'h14, 32'h0,         2'b10, 0, 0, 32'hA5A5_0000, 0);
        do_req(0, 1, 32'hFC, 32'h55AA_55AA, 2'b10, 0, 0, 32'h0, 0);
        do_req(0, 0, 32'hFC, 32'h0,         2'b10, 0, 0, 32'h55AA_55AA, 0);
        // WAIT=3 instance: reset during the wait of a store leaves memory intact
        do_req(1, 1, 32'h20, 32'h1122_3344, 2'b10, 0, 0, 32'h0, 0);
        do_req(1, 0, 32'h20, 32'h0,         2'b10, 0, 2, 32'h1122_3344, 0);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'hAAAA_AAAA; req_size[1] = 2'b10;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        exp_rdata[1] = 32'd0; exp_err[1] = 1'b0; rsp_cyc[1] = cyc + 3; pend[1] = 1'b1;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        pend[1] = 1'b0;
        #1;
        check("midreset_ready", 1, 32'(req_ready[1]), 32'd1);
        check("midreset_valid", 1, 32'(rsp_valid[1]), 32'd0);
        check("midreset_rdata", 1, rsp_rdata[1], 32'd0);
        check("midreset_err", 1, 32'(rsp_err[1]), 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        do_req(1, 0, 32'h20, 32'h0,         2'b10, 0, 0, 32'h1122_3344, 0);
        do_req(1, 0, 32'h23, 32'h0,         2'b00, 0, 0, 32'h0000_0011, 0);
        // WAIT=0 instance
        do_req(2, 1, 32'h04, 32'h0BAD_CAFE, 2'b10, 0, 0, 32'h0, 0);
        do_req(2, 0, 32'h07, 32'h0,         2'b00, 1, 0, 32'h0000_000B, 0);
        do_req(2, 0, 32'h05, 32'h0,         2'b00, 0, 0, 32'hFFFF_FFCA, 0);
        do_req(2, 0, 32'h06, 32'h0,         2'b01, 0, 3, 32'h0000_0BAD, 0);
        do_req(2, 0, 32'h05, 32'h0,         2'b10, 0, 0, 32'h0, 1);
        do_req(2, 1, 32'h04, 32'hFFFF_FFFF, 2'b11, 0, 0, 32'h0, 1);
        do_req(2, 0, 32'h04, 32'h0,         2'b10, 0, 0, 32'h0BAD_CAFE, 0);
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
